// File: rtl/implication_queue.sv
// -----------------------------------------------------------------------------
// implication_queue
//
// Buffers unit-clause implications from NUM_LANES per-clause evaluators for the
// assignment stage. Each accepted batch is filtered: a lane that repeats an
// earlier lane (same variable, same value) is dropped, and a lane that
// contradicts an earlier lane (same variable, opposite value) makes the whole
// batch a conflict. Surviving lanes are written in lane order into a circular
// FIFO that drains one implication per cycle over a valid/ready handshake.
// A conflict is sticky: it freezes the queue until flush or reset.
//
// Optional feature (compile-time macro):
//   IMPLQ_CAM_EN - additionally compare every unit lane against all entries
//                  held in the queue at the start of the cycle (duplicates are
//                  dropped, contradictions conflict the batch).
//
// Variable width comes from the MAX_VARS_BITS macro (default 8 if undefined).
//
// Ports:
//   clock             in   sole clock, rising edge
//   reset_n           in   asynchronous active-low reset
//   flush             in   synchronous clear of queue and conflict state
//   in_valid          in   batch present
//   in_ready          out  batch accepted when in_valid & in_ready
//   in_unit           in   per-lane unit_clause flag
//   in_variable       in   per-lane implied variable
//   in_val            in   per-lane implied value
//   out_valid         out  head entry valid
//   out_ready         in   consumer takes head when out_valid & out_ready
//   out_variable      out  head variable
//   out_val           out  head value
//   conflict          out  sticky conflict flag
//   conflict_variable out  variable implied both ways
//   count             out  occupied entries
// -----------------------------------------------------------------------------
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module implication_queue #(
    parameter int NUM_LANES = 4,
    parameter int DEPTH     = 8
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic                                       flush,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [NUM_LANES-1:0]                       in_unit,
    input  logic [NUM_LANES-1:0][`MAX_VARS_BITS-1:0]   in_variable,
    input  logic [NUM_LANES-1:0]                       in_val,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [`MAX_VARS_BITS-1:0]                  out_variable,
    output logic                                       out_val,
    output logic                                       conflict,
    output logic [`MAX_VARS_BITS-1:0]                  conflict_variable,
    output logic [$clog2(DEPTH+1)-1:0]                 count
);

    localparam int VW = `MAX_VARS_BITS;
    localparam int CW = $clog2(DEPTH + 1);
    // A single-entry queue still needs a one-bit pointer; wrap() keeps it at 0.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - NUM_LANES);

    // Reduce an arbitrary non-negative index to a slot number.
    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % DEPTH);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          conflict_q, conflict_d;
    logic [VW-1:0] conflict_variable_q, conflict_variable_d;

    logic [VW-1:0] mem_var_q [DEPTH];
    logic [VW-1:0] mem_var_d [DEPTH];
    logic          mem_val_q [DEPTH];
    logic          mem_val_d [DEPTH];

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic accept;
    logic pop;

    // Admission uses the registered count only, so a same-cycle pop never
    // frees room for the incoming batch.
    assign in_ready  = ~conflict_q & (count_q <= FILL_LIMIT);
    assign out_valid = (count_q != '0) & ~conflict_q;
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Storage is not reset, so the head is masked to keep the outputs at zero
    // whenever nothing valid is presented.
    assign out_variable      = out_valid ? mem_var_q[head_q] : '0;
    assign out_val           = out_valid ? mem_val_q[head_q] : 1'b0;
    assign conflict          = conflict_q;
    assign conflict_variable = conflict_variable_q;
    assign count             = count_q;

`ifdef IMPLQ_CAM_EN
    // Occupancy mask of the queue as it stands at the start of the cycle; an
    // entry being popped this cycle is still included.
    logic [DEPTH-1:0] entry_valid;

    always_comb begin
        entry_valid = '0;
        for (int e = 0; e < DEPTH; e++) begin
            entry_valid[e] = int'(wrap(e - int'(head_q) + DEPTH)) < int'(count_q);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Batch filtering
    // -------------------------------------------------------------------------
    logic [NUM_LANES-1:0] lane_drop;
    logic [NUM_LANES-1:0] lane_conf;
    logic [NUM_LANES-1:0] keep;
    logic                 batch_conflict;
    logic [VW-1:0]        batch_conflict_var;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        lane_drop          = '0;
        lane_conf          = '0;
        keep               = '0;
        batch_conflict     = 1'b0;
        batch_conflict_var = '0;

        for (int j = 0; j < NUM_LANES; j++) begin
            if (in_unit[j]) begin
                // Compare against earlier unit lanes of the same batch.
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (i < j && in_unit[i] && in_variable[i] == in_variable[j]) begin
                        if (in_val[i] == in_val[j]) begin
                            lane_drop[j] = 1'b1;
                        end else begin
                            lane_conf[j] = 1'b1;
                        end
                    end
                end
`ifdef IMPLQ_CAM_EN
                // Compare against implications already waiting in the queue.
                for (int e = 0; e < DEPTH; e++) begin
                    if (entry_valid[e] && mem_var_q[e] == in_variable[j]) begin
                        if (mem_val_q[e] == in_val[j]) begin
                            lane_drop[j] = 1'b1;
                        end else begin
                            lane_conf[j] = 1'b1;
                        end
                    end
                end
`endif
                keep[j] = ~lane_drop[j] & ~lane_conf[j];
                // Ascending scan: the first conflicting lane is the one reported.
                if (lane_conf[j] && !batch_conflict) begin
                    batch_conflict     = 1'b1;
                    batch_conflict_var = in_variable[j];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: compaction of survivors, pointers, count, conflict
    // -------------------------------------------------------------------------
    logic [CW-1:0] push_n;

    always_comb begin
        mem_var_d           = mem_var_q;
        mem_val_d           = mem_val_q;
        push_n              = '0;
        head_d              = head_q;
        tail_d              = tail_q;
        count_d             = count_q;
        conflict_d          = conflict_q;
        conflict_variable_d = conflict_variable_q;

        if (accept && !batch_conflict) begin
            // Survivors land in consecutive slots from tail in lane order;
            // push_n doubles as the running write offset.
            for (int j = 0; j < NUM_LANES; j++) begin
                if (keep[j]) begin
                    mem_var_d[wrap(int'(tail_q) + int'(push_n))] = in_variable[j];
                    mem_val_d[wrap(int'(tail_q) + int'(push_n))] = in_val[j];
                    push_n = push_n + 1'b1;
                end
            end
        end

        if (flush) begin
            head_d              = '0;
            tail_d              = '0;
            count_d             = '0;
            conflict_d          = 1'b0;
            conflict_variable_d = '0;
        end else begin
            if (accept && batch_conflict) begin
                conflict_d          = 1'b1;
                conflict_variable_d = batch_conflict_var;
            end
            tail_d  = wrap(int'(tail_q) + int'(push_n));
            head_d  = pop ? wrap(int'(head_q) + 1) : head_q;
            count_d = count_q + push_n - CW'(pop);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q              <= '0;
            tail_q              <= '0;
            count_q             <= '0;
            conflict_q          <= 1'b0;
            conflict_variable_q <= '0;
        end else begin
            head_q              <= head_d;
            tail_q              <= tail_d;
            count_q             <= count_d;
            conflict_q          <= conflict_d;
            conflict_variable_q <= conflict_variable_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever observed
    // after it has been written, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clock) begin
        mem_var_q <= mem_var_d;
        mem_val_q <= mem_val_d;
    end

endmodule

// File: tb/tb_implication_queue.sv
// -----------------------------------------------------------------------------
// tb_implication_queue
//
// Directed bench for implication_queue (NUM_LANES=4, DEPTH=8). The stimulus
// process pushes the hand-derived sequence of implications it expects to see
// leave the queue into a scoreboard queue; a monitor pops and compares every
// time the DUT completes an output handshake. Registered status (count,
// conflict, in_ready) is checked directly by the stimulus process.
// Honours IMPLQ_CAM_EN the same way the design does.
// -----------------------------------------------------------------------------
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module tb_implication_queue;

    localparam int NUM_LANES = 4;
    localparam int DEPTH     = 8;
    localparam int VW        = `MAX_VARS_BITS;
    localparam int CW        = $clog2(DEPTH + 1);

    logic                              clock;
    logic                              reset_n;
    logic                              flush;
    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_LANES-1:0]              in_unit;
    logic [NUM_LANES-1:0][VW-1:0]      in_variable;
    logic [NUM_LANES-1:0]              in_val;
    logic                              out_valid;
    logic                              out_ready;
    logic [VW-1:0]                     out_variable;
    logic                              out_val;
    logic                              conflict;
    logic [VW-1:0]                     conflict_variable;
    logic [CW-1:0]                     count;

    implication_queue #(
        .NUM_LANES(NUM_LANES),
        .DEPTH    (DEPTH)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_unit          (in_unit),
        .in_variable      (in_variable),
        .in_val           (in_val),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_variable     (out_variable),
        .out_val          (out_val),
        .conflict         (conflict),
        .conflict_variable(conflict_variable),
        .count            (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [VW:0] exp_q [$];   // {variable, val}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int v, input logic b);
        exp_q.push_back({VW'(v), b});
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one batch for exactly one edge, returning just after that edge.
    task automatic send(input logic [3:0] unit, input logic [3:0] vals,
                        input int v0, input int v1, input int v2, input int v3);
        in_unit        = unit;
        in_val         = vals;
        in_variable[0] = VW'(v0);
        in_variable[1] = VW'(v1);
        in_variable[2] = VW'(v2);
        in_variable[3] = VW'(v3);
        in_valid       = 1'b1;
        step();
        in_valid = 1'b0;
        in_unit  = '0;
    endtask

    // Drain with out_ready=1 until empty, bounded.
    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (count != '0 && n < 20) begin
            step();
            n++;
        end
        check(name, 32'(count), 0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 0);
    endtask

    // Monitor: compare every completed output handshake against the scoreboard.
    always @(negedge clock) begin
        if (reset_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got var %0d val %0d, expected nothing", out_variable, out_val);
            end else begin
                logic [VW:0] e;
                e = exp_q.pop_front();
                check("pop_var", 32'(out_variable), 32'(e[VW:1]));
                check("pop_val", 32'(out_val), 32'(e[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_unit     = '0;
        in_variable = '0;
        in_val      = '0;
        out_ready   = 1'b0;

        // ---------------- Reset state ----------------
        step();
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_variable", 32'(out_variable), 0);
        check("rst_conflict", 32'(conflict), 0);
        step();
        reset_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_conflict_variable", 32'(conflict_variable), 0);
        check("rst_out_val", 32'(out_val), 0);

        // ---------------- Two lanes with a gap ----------------
        out_ready = 1'b1;
        push_exp(5, 1'b1);
        push_exp(9, 1'b0);
        send(4'b0101, 4'b0001, 5, 0, 9, 0);
        check("b1_count", 32'(count), 2);
        check("b1_head_var", 32'(out_variable), 5);
        check("b1_head_val", 32'(out_val), 1);
        step();
        check("b1_second_var", 32'(out_variable), 9);
        check("b1_second_val", 32'(out_val), 0);
        step();
        check("b1_empty_valid", 32'(out_valid), 0);

        // ---------------- In-batch duplicates ----------------
        out_ready = 1'b0;
        push_exp(3, 1'b1);
        send(4'b1011, 4'b1011, 3, 3, 0, 3);
        check("dup_count", 32'(count), 1);
        drain("dup_drain");

        // ---------------- All-zero batch is a no-op ----------------
        send(4'b0000, 4'b1111, 1, 2, 3, 4);
        check("noop_count", 32'(count), 0);
        check("noop_in_ready", 32'(in_ready), 1);

        // ---------------- In-batch conflict, then flush ----------------
        out_ready = 1'b0;
        push_exp(11, 1'b1);
        send(4'b0001, 4'b0001, 11, 0, 0, 0);
        check("pre_conf_count", 32'(count), 1);
        send(4'b0110, 4'b0100, 0, 7, 7, 0);
        check("conf_flag", 32'(conflict), 1);
        check("conf_var", 32'(conflict_variable), 7);
        check("conf_count", 32'(count), 1);
        check("conf_in_ready", 32'(in_ready), 0);
        check("conf_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        step();
        check("conf_frozen_count", 32'(count), 1);
        check("conf_frozen_flag", 32'(conflict), 1);
        out_ready = 1'b0;
        flush = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
        check("flush_conflict", 32'(conflict), 0);
        check("flush_conf_var", 32'(conflict_variable), 0);
        check("flush_count", 32'(count), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        check("flush_out_valid", 32'(out_valid), 0);

        // ---------------- Move pointers to 3, then fill across the wrap ----------------
        out_ready = 1'b1;
        push_exp(20, 1'b0);
        push_exp(21, 1'b1);
        push_exp(22, 1'b0);
        send(4'b0111, 4'b0010, 20, 21, 22, 0);
        drain("offset_drain");

        out_ready = 1'b0;
        push_exp(30, 1'b1);
        push_exp(31, 1'b0);
        push_exp(32, 1'b1);
        push_exp(33, 1'b0);
        send(4'b1111, 4'b0101, 30, 31, 32, 33);
        check("fill4_count", 32'(count), 4);
        check("fill4_in_ready", 32'(in_ready), 1);
        push_exp(34, 1'b0);
        push_exp(35, 1'b0);
        push_exp(36, 1'b1);
        push_exp(37, 1'b1);
        send(4'b1111, 4'b1100, 34, 35, 36, 37);
        check("full_count", 32'(count), 8);
        check("full_in_ready", 32'(in_ready), 0);
        // Batch offered while full, with a simultaneous pop: must be refused.
        out_ready = 1'b1;
        send(4'b0001, 4'b0001, 50, 0, 0, 0);
        check("full_pop_count", 32'(count), 7);
        check("full_pop_in_ready", 32'(in_ready), 0);
        drain("wrap_drain");

        // ---------------- Queue-versus-batch comparison ----------------
        out_ready = 1'b0;
        push_exp(4, 1'b1);
        send(4'b0001, 4'b0001, 4, 0, 0, 0);
        check("cam_seed_count", 32'(count), 1);
`ifdef IMPLQ_CAM_EN
        send(4'b0001, 4'b0001, 4, 0, 0, 0);
        check("cam_dup_count", 32'(count), 1);
        send(4'b0001, 4'b0000, 4, 0, 0, 0);
        check("cam_conf_flag", 32'(conflict), 1);
        check("cam_conf_var", 32'(conflict_variable), 4);
        check("cam_conf_count", 32'(count), 1);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
        check("cam_flush_count", 32'(count), 0);
`else
        push_exp(4, 1'b1);
        send(4'b0001, 4'b0001, 4, 0, 0, 0);
        check("nocam_dup_count", 32'(count), 2);
        push_exp(4, 1'b0);
        send(4'b0001, 4'b0000, 4, 0, 0, 0);
        check("nocam_conf_flag", 32'(conflict), 0);
        check("nocam_count", 32'(count), 3);
        drain("nocam_drain");
`endif

        // ---------------- Asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        push_exp(60, 1'b0);
        push_exp(61, 1'b0);
        push_exp(62, 1'b0);
        send(4'b0111, 4'b0000, 60, 61, 62, 0);
        check("pre_rst_count", 32'(count), 3);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_variable", 32'(out_variable), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        step();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check("post_rst_count", 32'(count), 0);
        check("post_rst_out_valid", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
